fir_mac: RTL and testbench

Time-multiplexed FIR filter core for the digital filter datapath. It accepts one signed Q7.8 sample per handshake and shifts it into a TAPS-deep delay line. It then sequences one tap per clock through a single instance of the team's 16-bit saturating Q7.8 `Multiplication` block, feeding it operands and consuming its product. Products are accumulated with saturation, and one filtered Q7.8 result is emitted per accepted sample.

---
 rtl/fir_mac.sv | 115 +++++++++++
 tb/tb_fir_mac.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac.sv
// Time-multiplexed FIR core: one Q7.8 sample in, TAPS sequential MAC steps
// through a single saturating multiplier, one saturated Q7.8 result out.

module Multiplication #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);
  logic signed [2*N-1:0] full;

  // Product is truncated (floor) to Q7.8; out-of-range values clamp to the rails.
  always_comb begin
    full = $signed(a) * $signed(b);
    if (full[2*N-1:N+FRAC-1] == {(N-FRAC+1){full[2*N-1]}})
      p = full[N+FRAC-1:FRAC];
    else
      p = full[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
endmodule

module fir_mac #(
  parameter int N    = 16,
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic          out_valid,
  output logic [N-1:0]  out_data
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  x [TAPS];
  logic [N-1:0]  c [TAPS];
  logic [N-1:0]  acc;
  logic [AW-1:0] idx;

  logic [N-1:0]  mul_a;
  logic [N-1:0]  mul_b;
  logic [N-1:0]  prod;
  logic [N:0]    sum;
  logic [N-1:0]  acc_next;

  assign in_ready = (state == IDLE);
  assign mul_a    = c[idx];
  assign mul_b    = x[idx];

  Multiplication #(.N(N), .FRAC(8)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Sign-extended (N+1)-bit add; overflow shows as disagreeing top two bits.
  always_comb begin
    sum = {acc[N-1], acc} + {prod[N-1], prod};
    if (sum[N] != sum[N-1])
      acc_next = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      acc_next = sum[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_we && (int'(coef_addr) < TAPS))
            c[coef_addr] <= coef_data;
          if (in_valid) begin
            for (int unsigned k = 1; k < TAPS; k++)
              x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == AW'(TAPS - 1)) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac.sv
// Self-checking bench for fir_mac: directed plan cases plus random samples and
// coefficients, checked against an arithmetic reference model.

module tb_fir_mac;
  localparam int N    = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic          out_valid;
  logic [N-1:0]  out_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] xm [TAPS];
  logic [15:0] cm [TAPS];
  logic [15:0] imp [9];
  logic [15:0] last_out;

  fir_mac #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    p = p >>> 8;
    return sat16(p);
  endfunction

  function automatic logic [15:0] model_out();
    int acc = 0;
    for (int k = 0; k < TAPS; k++)
      acc = int'($signed(sat16(acc + int'($signed(qmul(cm[k], xm[k]))))));
    return acc[15:0];
  endfunction

  function automatic void model_push(input logic [15:0] d);
    for (int k = TAPS - 1; k >= 1; k--) xm[k] = xm[k-1];
    xm[0] = d;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) begin
      xm[k] = '0;
      cm[k] = '0;
    end
  endfunction

  task automatic wr_coef(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    cm[a] = d;
  endtask

  // Accept one sample, check busy window, latency and result; optionally
  // pulse a coefficient write mid-MAC that must have no effect.
  task automatic send(input logic [15:0] d, input bit lock_write, input string tag);
    logic [15:0] exp;
    int n;
    bit busy_ok;
    @(negedge clk);
    check({tag, "_rdy"}, {15'd0, in_ready}, 16'd1);
    check({tag, "_ovidle"}, {15'd0, out_valid}, 16'd0);
    in_valid = 1'b1; in_data = d;
    model_push(d);
    exp = model_out();
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; busy_ok = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      coef_we = lock_write && (n == 3);
      coef_addr = '0; coef_data = 16'h7FFF;
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) break;
    end
    coef_we = 1'b0;
    check({tag, "_lat"}, 16'(n - 1), 16'd8);
    check({tag, "_busy"}, {15'd0, busy_ok}, 16'd1);
    check({tag, "_data"}, out_data, exp);
    last_out = out_data;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check("rst_ov", {15'd0, out_valid}, 16'd0);
    check("rst_od", out_data, 16'h0000);
    check("rst_rdy", {15'd0, in_ready}, 16'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'((k + 1) * 16'h0100));
  endtask

  task automatic impulse(input bit record, input string tag);
    send(16'h0100, 1'b0, tag);
    if (record) imp[0] = last_out; else check({tag, "_same"}, last_out, imp[0]);
    for (int i = 1; i < 9; i++) begin
      send(16'h0000, 1'b0, tag);
      if (record) imp[i] = last_out; else check({tag, "_same"}, last_out, imp[i]);
    end
  endtask

  initial begin
    int acc_t [$];
    int outs;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_clear();
    #12;
    check("init_ov", {15'd0, out_valid}, 16'd0);
    check("init_od", out_data, 16'h0000);
    check("init_rdy", {15'd0, in_ready}, 16'd1);
    @(negedge clk); rst_n = 1'b1;

    send(16'h0100, 1'b0, "zero_coef");
    check("zero_coef_const", last_out, 16'h0000);

    do_reset();
    load_ramp();
    impulse(1'b1, "imp");
    for (int i = 0; i < 8; i++) check("imp_const", imp[i], 16'((i + 1) * 16'h0100));
    check("imp_tail", imp[8], 16'h0000);

    // Write during MAC must be ignored: next impulse still sees c[0]=0x0100.
    send(16'h0100, 1'b1, "lock");
    send(16'h0000, 1'b0, "lock_next");
    check("lock_c1", last_out, 16'h0200);
    do_reset();
    load_ramp();
    send(16'h0100, 1'b0, "lock_c0");
    check("lock_c0_const", last_out, 16'h0100);

    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h0080);
    for (int i = 0; i < 10; i++) begin
      send(16'h0100, 1'b0, "step");
      check("step_const", last_out, 16'((i < 8 ? i + 1 : 8) * 16'h0080));
    end

    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'h0100);
    send(16'h4000, 1'b0, "acc_sat");
    check("acc_sat1", last_out, 16'h4000);
    send(16'h4000, 1'b0, "acc_sat");
    check("acc_sat2", last_out, 16'h7FFF);

    do_reset();
    wr_coef(3'd0, 16'h0540);
    send(16'h7F80, 1'b0, "mul_sat");
    check("mul_sat_const", last_out, 16'h7FFF);

    // Continuous in_valid: accepts every TAPS+2 cycles.
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(AW'(k), 16'($urandom_range(0, 16'h0200)));
    outs = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0100;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (cyc >= 31) in_valid = 1'b0;
      if (out_valid) begin
        check("hs_data", out_data, 16'(acc_t.pop_front()));
        outs++;
      end
      if (in_valid && in_ready) begin
        model_push(16'h0100);
        acc_t.push_back(int'(model_out()));
        acc_t.push_back(cyc);
        acc_t.push_back(int'(model_out()));
        void'(acc_t.pop_back());
        void'(acc_t.pop_back());
        if (cyc != 0) check("hs_space", 16'(cyc % (TAPS + 2)), 16'd0);
      end
    end
    check("hs_count", 16'(outs), 16'd4);
    in_valid = 1'b0;

    // Reset while idx=3: no output for that sample, delay line cleared.
    do_reset();
    load_ramp();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    seen = 1'b0;
    repeat (3) @(negedge clk) if (out_valid) seen = 1'b1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk) if (out_valid) seen = 1'b1;
    check("midrst_noout", {15'd0, seen}, 16'd0);
    load_ramp();
    impulse(1'b0, "imp2");

    // Random coefficients and samples.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        wr_coef(AW'($urandom_range(0, TAPS - 1)), 16'($urandom));
      send(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0400) - 16'h0200),
           1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
